// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter onto a single memory port.
// One transaction outstanding at a time; fetch returns the 32-bit word selected by addr[2].
module mem_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ireq_valid,
    input  logic [DATA_W-1:0]   ireq_addr,
    output logic                iresp_addr_ok,
    output logic                iresp_data_ok,
    output logic [DATA_W/2-1:0] iresp_data,

    input  logic                dreq_valid,
    input  logic [DATA_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [7:0]          dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_data,
    output logic                dresp_addr_ok,
    output logic                dresp_data_ok,
    output logic [DATA_W-1:0]   dresp_data,

    output logic                mreq_valid,
    output logic                mreq_write,
    output logic [DATA_W-1:0]   mreq_addr,
    output logic [2:0]          mreq_size,
    output logic [7:0]          mreq_strobe,
    output logic [DATA_W-1:0]   mreq_data,
    input  logic                mresp_ready,
    input  logic                mresp_valid,
    input  logic [DATA_W-1:0]   mresp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    state_t              state;
    state_t              state_nxt;
    logic                owner;
    logic                last_grant;
    logic                grant_i;
    logic                grant_d;
    logic                complete;

    logic [DATA_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [7:0]          strobe_q;
    logic [DATA_W-1:0]   data_q;
    logic                write_q;

    // Fetch reads are 32-bit; pick the half of the 64-bit beat that addr[2] names.
    function automatic logic [DATA_W/2-1:0] select_word(input logic          hi,
                                                        input logic [DATA_W-1:0] beat);
        return hi ? beat[DATA_W-1:DATA_W/2] : beat[DATA_W/2-1:0];
    endfunction

    // Next-state, grant and completion decode; everything is suppressed while in reset.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (dreq_valid && (!ireq_valid || last_grant == SRC_I)) begin
                        grant_d = 1'b1;
                    end else if (ireq_valid) begin
                        grant_i = 1'b1;
                    end
                    if (grant_i || grant_d) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (mresp_ready) begin
                        if (mresp_valid) begin
                            complete  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mresp_valid) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= SRC_D;
            last_grant <= SRC_I;
            addr_q     <= '0;
            size_q     <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                owner      <= SRC_D;
                last_grant <= SRC_D;
                addr_q     <= dreq_addr;
                size_q     <= dreq_size;
                strobe_q   <= dreq_strobe;
                data_q     <= dreq_data;
                write_q    <= (dreq_strobe != 8'h00);
            end else if (grant_i) begin
                owner      <= SRC_I;
                last_grant <= SRC_I;
                addr_q     <= ireq_addr;
                size_q     <= 3'd2;
                strobe_q   <= 8'h00;
                data_q     <= '0;
                write_q    <= 1'b0;
            end
        end
    end

    // Memory request fields are only presented while the request is in flight.
    always_comb begin
        mreq_valid  = rst && (state == REQ);
        mreq_write  = mreq_valid ? write_q  : 1'b0;
        mreq_addr   = mreq_valid ? addr_q   : '0;
        mreq_size   = mreq_valid ? size_q   : 3'd0;
        mreq_strobe = mreq_valid ? strobe_q : 8'h00;
        mreq_data   = mreq_valid ? data_q   : '0;
    end

    always_comb begin
        iresp_addr_ok = grant_i;
        dresp_addr_ok = grant_d;
        iresp_data_ok = complete && (owner == SRC_I);
        dresp_data_ok = complete && (owner == SRC_D);
        iresp_data    = iresp_data_ok ? select_word(addr_q[2], mresp_data) : '0;
        dresp_data    = dresp_data_ok ? mresp_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mreq_valid, mreq_write;
    logic [63:0] mreq_addr;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_ready, mresp_valid;
    logic [63:0] mresp_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one pending transaction, whether memory has accepted it, who owns it.
    bit          m_busy   = 1'b0;
    bit          m_sent   = 1'b0;
    bit          m_own_d  = 1'b1;
    bit          m_last_d = 1'b0;
    logic [63:0] p_addr   = '0;
    logic [2:0]  p_size   = '0;
    logic [7:0]  p_strobe = '0;
    logic [63:0] p_data   = '0;
    bit          p_write  = 1'b0;
    bit          g_i = 1'b0, g_d = 1'b0, done = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_write(mreq_write), .mreq_addr(mreq_addr),
        .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
        .mresp_ready(mresp_ready), .mresp_valid(mresp_valid), .mresp_data(mresp_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called right after inputs are driven on a falling edge; returns on the next falling edge.
    task automatic step();
        logic        e_iaok, e_daok, e_iok, e_dok, e_mv, e_mw;
        logic [31:0] e_id;
        logic [63:0] e_dd, e_ma, e_md;
        logic [2:0]  e_ms;
        logic [7:0]  e_mst;
        #1;
        e_iaok = 0; e_daok = 0; e_iok = 0; e_dok = 0; e_mv = 0; e_mw = 0;
        e_id = '0; e_dd = '0; e_ma = '0; e_md = '0; e_ms = '0; e_mst = '0;
        g_i = 0; g_d = 0; done = 0;
        if (rst) begin
            if (!m_busy) begin
                if (ireq_valid && dreq_valid) begin
                    g_d = !m_last_d;
                    g_i = m_last_d;
                end else begin
                    g_d = dreq_valid;
                    g_i = ireq_valid;
                end
            end else if (!m_sent) begin
                e_mv = 1; e_mw = p_write; e_ma = p_addr; e_ms = p_size;
                e_mst = p_strobe; e_md = p_data;
                done = mresp_ready && mresp_valid;
            end else begin
                done = mresp_valid;
            end
            e_iaok = g_i;
            e_daok = g_d;
            if (done && m_own_d) begin
                e_dok = 1; e_dd = mresp_data;
            end
            if (done && !m_own_d) begin
                e_iok = 1;
                e_id  = p_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
            end
        end
        check("iresp_addr_ok", 64'(iresp_addr_ok), 64'(e_iaok));
        check("dresp_addr_ok", 64'(dresp_addr_ok), 64'(e_daok));
        check("iresp_data_ok", 64'(iresp_data_ok), 64'(e_iok));
        check("iresp_data",    64'(iresp_data),    64'(e_id));
        check("dresp_data_ok", 64'(dresp_data_ok), 64'(e_dok));
        check("dresp_data",    dresp_data,         e_dd);
        check("mreq_valid",    64'(mreq_valid),    64'(e_mv));
        check("mreq_write",    64'(mreq_write),    64'(e_mw));
        check("mreq_addr",     mreq_addr,          e_ma);
        check("mreq_size",     64'(mreq_size),     64'(e_ms));
        check("mreq_strobe",   64'(mreq_strobe),   64'(e_mst));
        check("mreq_data",     mreq_data,          e_md);
        @(posedge clk);
        if (!rst) begin
            m_busy = 0; m_sent = 0; m_own_d = 1; m_last_d = 0;
        end else if (g_d) begin
            m_busy = 1; m_sent = 0; m_own_d = 1; m_last_d = 1;
            p_addr = dreq_addr; p_size = dreq_size; p_strobe = dreq_strobe;
            p_data = dreq_data; p_write = (dreq_strobe != 0);
        end else if (g_i) begin
            m_busy = 1; m_sent = 0; m_own_d = 0; m_last_d = 0;
            p_addr = ireq_addr; p_size = 3'd2; p_strobe = 8'h00;
            p_data = '0; p_write = 0;
        end else if (done) begin
            m_busy = 0;
        end else if (m_busy && !m_sent && mresp_ready) begin
            m_sent = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ireq_valid = 0; ireq_addr = '0;
        dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        mresp_ready = 0; mresp_valid = 0; mresp_data = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Reset with every input active: all outputs must stay low.
        ireq_valid = 1; dreq_valid = 1; mresp_ready = 1; mresp_valid = 1;
        mresp_data = 64'hFFFF_0000_FFFF_0000; dreq_strobe = 8'hFF;
        step();
        step();
        rst = 1'b1;
        idle_inputs();

        // Data read with a one-cycle accept and a later response.
        dreq_valid = 1; dreq_addr = 64'h8000_0010; dreq_size = 3'd3; dreq_strobe = 8'h00;
        #1; check("rd_addr_ok", 64'(dresp_addr_ok), 64'd1);
        step();
        idle_inputs(); mresp_ready = 1;
        #1; check("rd_mreq_valid", 64'(mreq_valid), 64'd1);
        check("rd_mreq_write", 64'(mreq_write), 64'd0);
        check("rd_mreq_addr", mreq_addr, 64'h8000_0010);
        step();
        idle_inputs();
        step();
        mresp_valid = 1; mresp_data = 64'h1122_3344_5566_7788;
        #1; check("rd_data_ok", 64'(dresp_data_ok), 64'd1);
        check("rd_data", dresp_data, 64'h1122_3344_5566_7788);
        step();
        idle_inputs();
        step();

        // Fetch from the upper word.
        ireq_valid = 1; ireq_addr = 64'h8000_0004;
        step();
        idle_inputs(); mresp_ready = 1; mresp_valid = 1; mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        #1; check("if_data_ok", 64'(iresp_data_ok), 64'd1);
        check("if_data", 64'(iresp_data), 64'hAAAA_BBBB);
        step();
        idle_inputs();
        #1; check("if_data_ok_drop", 64'(iresp_data_ok), 64'd0);
        step();

        // Write accepted and completed in the first request cycle.
        dreq_valid = 1; dreq_addr = 64'h8000_0100; dreq_size = 3'd2;
        dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF;
        step();
        idle_inputs(); mresp_ready = 1; mresp_valid = 1; mresp_data = 64'h55;
        #1; check("wr_write", 64'(mreq_write), 64'd1);
        check("wr_strobe", 64'(mreq_strobe), 64'h0F);
        check("wr_data", mreq_data, 64'hDEAD_BEEF);
        check("wr_data_ok", 64'(dresp_data_ok), 64'd1);
        step();
        idle_inputs();
        #1; check("wr_idle_after", 64'(mreq_valid), 64'd0);
        step();

        // Memory stalls for 5 cycles while a fetch waits.
        dreq_valid = 1; dreq_addr = 64'h8000_0200; dreq_size = 3'd3; dreq_strobe = 8'h00;
        step();
        idle_inputs(); ireq_valid = 1; ireq_addr = 64'h8000_0300;
        for (int k = 0; k < 5; k++) begin
            #1; check("stall_no_grant", 64'(iresp_addr_ok), 64'd0);
            check("stall_addr", mreq_addr, 64'h8000_0200);
            step();
        end
        mresp_ready = 1; mresp_valid = 1; mresp_data = 64'h0123_4567_89AB_CDEF;
        #1; check("no_grant_on_done", 64'(iresp_addr_ok), 64'd0);
        step();
        mresp_ready = 0; mresp_valid = 0;
        #1; check("fetch_grant_after", 64'(iresp_addr_ok), 64'd1);
        step();
        idle_inputs(); mresp_ready = 1; mresp_valid = 1; mresp_data = 64'h0123_4567_89AB_CDEF;
        step();
        idle_inputs();

        // Reset while waiting for data abandons the transaction.
        dreq_valid = 1; dreq_addr = 64'h8000_0400; dreq_strobe = 8'h00;
        step();
        idle_inputs(); mresp_ready = 1;
        step();
        idle_inputs(); rst = 1'b0; ireq_valid = 1; dreq_valid = 1;
        #1; check("rst_mreq_valid", 64'(mreq_valid), 64'd0);
        check("rst_addr_ok", 64'(dresp_addr_ok), 64'd0);
        step();
        step();
        rst = 1'b1; idle_inputs(); mresp_valid = 1; mresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1; check("abandoned_no_data_ok", 64'(dresp_data_ok), 64'd0);
        step();
        idle_inputs();

        // Both requesters held valid: D, I, D, I.
        ireq_valid = 1; ireq_addr = 64'h8000_0008; dreq_valid = 1; dreq_addr = 64'h8000_0018;
        for (int k = 0; k < 4; k++) begin
            mresp_ready = 0; mresp_valid = 0;
            #1; check("rr_d_grant", 64'(dresp_addr_ok), 64'((k % 2) == 0));
            check("rr_i_grant", 64'(iresp_addr_ok), 64'((k % 2) == 1));
            step();
            mresp_ready = 1; mresp_valid = 1; mresp_data = {$urandom, $urandom};
            step();
        end
        idle_inputs();
        step();

        // Randomized traffic, including occasional resets and stray responses.
        for (int c = 0; c < 3000; c++) begin
            if (g_i) ireq_valid = 0;
            if (g_d) dreq_valid = 0;
            if (!ireq_valid && $urandom_range(3) == 0) begin
                ireq_valid = 1;
                ireq_addr  = {$urandom, $urandom};
            end
            if (!dreq_valid && $urandom_range(3) == 0) begin
                dreq_valid  = 1;
                dreq_addr   = {$urandom, $urandom};
                dreq_size   = 3'($urandom_range(3));
                dreq_strobe = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
                dreq_data   = {$urandom, $urandom};
            end
            mresp_ready = 1'($urandom_range(1));
            mresp_valid = ($urandom_range(2) == 0);
            mresp_data  = {$urandom, $urandom};
            rst         = ($urandom_range(199) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
